// File: rtl/la_rrarb3_pkg.sv
// Shared definitions for the la_rrarb3 arbiter: state encoding and width helpers.
package la_arb_defs;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Ceiling log2; evaluated at elaboration to size the hold counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int maxhold);
    int w;
    w = clog2(maxhold + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id >= 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/la_rrpick3.sv
// Combinational round-robin pick over three candidates, scanning ptr, ptr+1, ptr+2 mod 3.
module la_rrpick3
  import la_arb_defs::*;
(
  input  logic [2:0] mask,
  input  logic [1:0] ptr,
  output logic [2:0] onehot,
  output logic [1:0] id,
  output logic       any
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  // An out-of-range pointer is treated as 0 so the scan order stays well defined.
  always_comb begin
    c0 = (ptr == 2'd3) ? 2'd0 : ptr;
    c1 = next_id(c0);
    c2 = next_id(c1);
  end

  always_comb begin
    onehot = 3'b000;
    id     = 2'd0;
    any    = |mask;
    if (mask[c0]) begin
      onehot[c0] = 1'b1;
      id         = c0;
    end else if (mask[c1]) begin
      onehot[c1] = 1'b1;
      id         = c1;
    end else if (mask[c2]) begin
      onehot[c2] = 1'b1;
      id         = c2;
    end
  end

endmodule

// File: rtl/la_rrarb3.sv
// 3-requester round-robin arbiter with grant hold and max-hold preemption.
// Registered one-hot grant with zero-bubble handoff between owners.
module la_rrarb3
  import la_arb_defs::*;
#(
  parameter string PROP    = "DEFAULT",
  parameter int    MAXHOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       gnt_vld,
  output logic [1:0] gnt_id,
  output logic       preempt
);

  localparam int            CW      = cnt_width(MAXHOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXHOLD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // PROP is a pass-through tag; there are no implementation variants to select.
  if (PROP == "") begin : g_prop_unset
  end

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    ptr_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    grant_nxt;
  logic [1:0]    id_nxt;
  logic          pre_nxt;

  logic [2:0]    pick_mask;
  logic [2:0]    pick_onehot;
  logic [1:0]    pick_id;
  logic          pick_any;
  logic          owner_hit;
  logic          cnt_at_max;
  logic          do_preempt;
  logic          take_new;

  // grant is zero in IDLE, so masking with it only ever excludes a live owner.
  always_comb begin
    owner_hit  = |(req & grant);
    pick_mask  = (state == ARB_IDLE) ? req : (req & ~grant);
    cnt_at_max = (MAXHOLD != 0) && (cnt == CNT_MAX);
    do_preempt = (state == ARB_BUSY) && owner_hit && cnt_at_max && en && pick_any;
    take_new   = en && pick_any && ((state == ARB_IDLE) || !owner_hit || do_preempt);
  end

  la_rrpick3 u_pick (
    .mask   (pick_mask),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (take_new) state_nxt = ARB_BUSY;
      ARB_BUSY: if (!owner_hit && !take_new) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = grant;
    id_nxt    = gnt_id;
    pre_nxt   = 1'b0;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    if (take_new) begin
      grant_nxt = pick_onehot;
      id_nxt    = pick_id;
      pre_nxt   = do_preempt;
      cnt_nxt   = CNT_ONE;
      ptr_nxt   = next_id(pick_id);
    end else if ((state == ARB_BUSY) && owner_hit) begin
      if (MAXHOLD == 0)     cnt_nxt = CNT_ONE;
      else if (!cnt_at_max) cnt_nxt = cnt + CNT_ONE;
    end else begin
      grant_nxt = 3'b000;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant   <= 3'b000;
      gnt_vld <= 1'b0;
      gnt_id  <= 2'd0;
      preempt <= 1'b0;
      ptr     <= 2'd0;
      cnt     <= '0;
    end else begin
      grant   <= grant_nxt;
      gnt_vld <= |grant_nxt;
      gnt_id  <= id_nxt;
      preempt <= pre_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_la_rrarb3.sv
// Directed scoreboard bench for la_rrarb3: MAXHOLD=4 instance plus a MAXHOLD=0 instance.
module tb_la_rrarb3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] req;
  logic [2:0] req0;
  logic [2:0] grant;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       preempt;
  logic [2:0] grant0;
  logic       gnt_vld0;
  logic [1:0] gnt_id0;
  logic       preempt0;

  int total;
  int bad;

  typedef struct {
    bit         sel;
    logic [2:0] grant;
    logic [1:0] id;
    logic       pre;
  } exp_t;

  exp_t sb[$];

  la_rrarb3 #(.PROP("DEFAULT"), .MAXHOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .grant   (grant),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .preempt (preempt)
  );

  la_rrarb3 #(.PROP("DEFAULT"), .MAXHOLD(0)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req0),
    .grant   (grant0),
    .gnt_vld (gnt_vld0),
    .gnt_id  (gnt_id0),
    .preempt (preempt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    exp_t       e;
    logic [2:0] og;
    logic [1:0] oid;
    logic       ov;
    logic       op;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s scoreboard empty: observed=none expected=entry", tag);
      return;
    end
    e   = sb.pop_front();
    og  = e.sel ? grant0   : grant;
    oid = e.sel ? gnt_id0  : gnt_id;
    ov  = e.sel ? gnt_vld0 : gnt_vld;
    op  = e.sel ? preempt0 : preempt;
    total++;
    assert (og === e.grant) else begin
      bad++;
      $error("[TB] FAIL %s grant observed=%b expected=%b", tag, og, e.grant);
    end
    total++;
    assert (oid === e.id) else begin
      bad++;
      $error("[TB] FAIL %s gnt_id observed=%0d expected=%0d", tag, oid, e.id);
    end
    total++;
    assert (ov === (|e.grant)) else begin
      bad++;
      $error("[TB] FAIL %s gnt_vld observed=%b expected=%b", tag, ov, |e.grant);
    end
    total++;
    assert (op === e.pre) else begin
      bad++;
      $error("[TB] FAIL %s preempt observed=%b expected=%b", tag, op, e.pre);
    end
  endtask

  // Drive one cycle of inputs, queue the registered result expected after the next edge.
  task automatic applyStimulus(input string tag, input bit sel, input logic r, input logic e,
                               input logic [2:0] q, input logic [2:0] eg,
                               input logic [1:0] eid, input logic ep);
    exp_t x;
    rst = r;
    en  = e;
    if (sel) req0 = q;
    else     req  = q;
    x.sel   = sel;
    x.grant = eg;
    x.id    = eid;
    x.pre   = ep;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    req   = 3'b000;
    req0  = 3'b000;
    @(negedge clk);

    applyStimulus("reset0", 0, 1, 0, 3'b000, 3'b000, 2'd0, 0);
    applyStimulus("reset1", 0, 1, 0, 3'b000, 3'b000, 2'd0, 0);

    applyStimulus("first",  0, 0, 1, 3'b111, 3'b001, 2'd0, 0);
    applyStimulus("drop0",  0, 0, 1, 3'b110, 3'b010, 2'd1, 0);
    applyStimulus("rot2",   0, 0, 1, 3'b101, 3'b100, 2'd2, 0);
    applyStimulus("rot0",   0, 0, 1, 3'b011, 3'b001, 2'd0, 0);
    applyStimulus("rot1",   0, 0, 1, 3'b110, 3'b010, 2'd1, 0);
    applyStimulus("rot2b",  0, 0, 1, 3'b101, 3'b100, 2'd2, 0);
    applyStimulus("idle",   0, 0, 1, 3'b000, 3'b000, 2'd2, 0);

    for (int i = 0; i < 4; i++)
      applyStimulus("hold0", 0, 0, 1, 3'b011, 3'b001, 2'd0, 0);
    applyStimulus("pre1",   0, 0, 1, 3'b011, 3'b010, 2'd1, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("hold1", 0, 0, 1, 3'b011, 3'b010, 2'd1, 0);
    applyStimulus("pre0",   0, 0, 1, 3'b011, 3'b001, 2'd0, 1);
    applyStimulus("idle2",  0, 0, 1, 3'b000, 3'b000, 2'd0, 0);

    applyStimulus("solo",   0, 0, 1, 3'b001, 3'b001, 2'd0, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus("solohold", 0, 0, 1, 3'b001, 3'b001, 2'd0, 0);
    applyStimulus("satpre", 0, 0, 1, 3'b011, 3'b010, 2'd1, 1);
    applyStimulus("keep1",  0, 0, 1, 3'b010, 3'b010, 2'd1, 0);
    applyStimulus("idle3",  0, 0, 1, 3'b000, 3'b000, 2'd1, 0);

    applyStimulus("rst4",   0, 1, 0, 3'b111, 3'b000, 2'd0, 0);
    applyStimulus("en0a",   0, 0, 0, 3'b111, 3'b000, 2'd0, 0);
    applyStimulus("en0b",   0, 0, 0, 3'b111, 3'b000, 2'd0, 0);
    applyStimulus("en1",    0, 0, 1, 3'b111, 3'b001, 2'd0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus("en0hold", 0, 0, 0, 3'b111, 3'b001, 2'd0, 0);
    applyStimulus("enpre",  0, 0, 1, 3'b111, 3'b010, 2'd1, 1);
    applyStimulus("en0rel", 0, 0, 0, 3'b101, 3'b000, 2'd1, 0);
    applyStimulus("en1p2",  0, 0, 1, 3'b101, 3'b100, 2'd2, 0);

    applyStimulus("rstbusy", 0, 1, 1, 3'b101, 3'b000, 2'd0, 0);
    applyStimulus("after",  0, 0, 1, 3'b110, 3'b010, 2'd1, 0);
    applyStimulus("rst5",   0, 1, 1, 3'b110, 3'b000, 2'd0, 0);
    applyStimulus("ptr0",   0, 0, 1, 3'b111, 3'b001, 2'd0, 0);
    applyStimulus("own0",   0, 0, 1, 3'b001, 3'b001, 2'd0, 0);
    applyStimulus("swap",   0, 0, 1, 3'b010, 3'b010, 2'd1, 0);
    applyStimulus("idle5",  0, 0, 1, 3'b000, 3'b000, 2'd1, 0);

    for (int i = 0; i < 100; i++)
      applyStimulus("nopre", 1, 0, 1, 3'b101, 3'b001, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
